// File: rtl/aes_encipher_block.sv
// AES-128 encipher datapath: one block in flight, SubBytes one 32-bit word per cycle via a shared S-box.
// Latency: ready returns 51 cycles after an accepted start (1 init + NUM_ROUNDS x (4 sub + 1 mix)).
// Backpressure: none queued; next is accepted only while idle with keyReady=1, otherwise dropped.
//
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   next, keyReady  start request / key store complete; start taken when both high in IDLE
//   block           128-bit plaintext, captured on the accepted start
//   round, roundKey round-key index out, matching round key back in the same cycle
//   beforeSub       word sent to shared S-box, afterSub its substituted value (same cycle)
//   newBlock, ready ciphertext and idle flag; newBlock valid and stable while ready=1
//   err             (only with AES_ENC_BUSY_ERR_EN) one-cycle pulse after a rejected next
// Optional feature macro: AES_ENC_BUSY_ERR_EN
module aes_encipher_block #(
   parameter int NUM_ROUNDS = 10
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         next,
   input  logic         keyReady,
   input  logic [127:0] block,
   output logic [3:0]   round,
   input  logic [127:0] roundKey,
   output logic [31:0]  beforeSub,
   input  logic [31:0]  afterSub,
   output logic [127:0] newBlock,
`ifdef AES_ENC_BUSY_ERR_EN
   output logic         err,
`endif
   output logic         ready
);

   typedef enum logic [1:0] {IDLE, INIT, SBOX, MAIN} state_t;

   localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

   state_t        state_q, state_d;
   logic [127:0]  data_q, data_d;
   logic [3:0]    round_q, round_d;
   logic          ready_q, ready_d;
   logic [1:0]    ctr_q, ctr_d;
`ifdef AES_ENC_BUSY_ERR_EN
   logic          err_q, err_d;
`endif

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
   endfunction

   function automatic logic [31:0] mix_col(input logic [31:0] w);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = w;
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

   function automatic logic [127:0] mix_columns(input logic [127:0] s);
      return {mix_col(s[127:96]), mix_col(s[95:64]), mix_col(s[63:32]), mix_col(s[31:0])};
   endfunction

   // Byte n = row (n%4) of column (n/4); byte 0 sits in [127:120].
   // Row r rotates left by r columns.
   function automatic logic [127:0] shift_rows(input logic [127:0] s);
      logic [7:0] b [16];
      for (int i = 0; i < 16; i++) b[i] = s[8*(15-i) +: 8];
      return {b[0],  b[5],  b[10], b[15],
              b[4],  b[9],  b[14], b[3],
              b[8],  b[13], b[2],  b[7],
              b[12], b[1],  b[6],  b[11]};
   endfunction

   function automatic logic [31:0] word_sel(input logic [127:0] s, input logic [1:0] idx);
      logic [31:0] w;
      case (idx)
         2'd0:    w = s[127:96];
         2'd1:    w = s[95:64];
         2'd2:    w = s[63:32];
         default: w = s[31:0];
      endcase
      return w;
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         data_q  <= '0;
         round_q <= '0;
         ready_q <= 1'b1;
         ctr_q   <= '0;
`ifdef AES_ENC_BUSY_ERR_EN
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         round_q <= round_d;
         ready_q <= ready_d;
         ctr_q   <= ctr_d;
`ifdef AES_ENC_BUSY_ERR_EN
         err_q   <= err_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      round_d = round_q;
      ready_d = ready_q;
      ctr_d   = ctr_q;
`ifdef AES_ENC_BUSY_ERR_EN
      // A request seen while busy or before the keys are stored is flagged, not queued.
      err_d   = next & (~ready_q | ~keyReady);
`endif
      case (state_q)
         IDLE: begin
            if (next && keyReady) begin
               data_d  = block;
               round_d = 4'd0;
               ready_d = 1'b0;
               state_d = INIT;
            end
         end
         INIT: begin
            data_d  = data_q ^ roundKey;
            round_d = 4'd1;
            ctr_d   = 2'd0;
            state_d = SBOX;
         end
         SBOX: begin
            case (ctr_q)
               2'd0:    data_d[127:96] = afterSub;
               2'd1:    data_d[95:64]  = afterSub;
               2'd2:    data_d[63:32]  = afterSub;
               default: data_d[31:0]   = afterSub;
            endcase
            ctr_d = ctr_q + 2'd1;
            if (ctr_q == 2'd3) state_d = MAIN;
         end
         MAIN: begin
            // Final round skips MixColumns; round stays at LAST_ROUND until the next start.
            if (round_q == LAST_ROUND) begin
               data_d  = shift_rows(data_q) ^ roundKey;
               ready_d = 1'b1;
               state_d = IDLE;
            end else begin
               data_d  = mix_columns(shift_rows(data_q)) ^ roundKey;
               round_d = round_q + 4'd1;
               state_d = SBOX;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outside SBOX the S-box still sees word 0; its result is simply not used.
   assign beforeSub = word_sel(data_q, (state_q == SBOX) ? ctr_q : 2'd0);
   assign round     = round_q;
   assign newBlock  = data_q;
   assign ready     = ready_q;
`ifdef AES_ENC_BUSY_ERR_EN
   assign err       = err_q;
`endif

endmodule

// File: tb/tb_aes_encipher_block.sv
module tb_aes_encipher_block;

   localparam int NR = 10;
   localparam logic [127:0] KEY_B = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
   localparam logic [127:0] PT_B  = 128'h3243f6a8_885a308d_313198a2_e0370734;
   localparam logic [127:0] CT_B  = 128'h3925841d_02dc09fb_dc118597_196a0b32;
   localparam logic [127:0] KEY_C = 128'h00010203_04050607_08090a0b_0c0d0e0f;
   localparam logic [127:0] PT_C  = 128'h00112233_44556677_8899aabb_ccddeeff;
   localparam logic [127:0] CT_C  = 128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         next = 1'b0;
   logic         keyReady = 1'b0;
   logic [127:0] block = '0;
   logic [3:0]   round;
   logic [127:0] roundKey;
   logic [31:0]  beforeSub;
   logic [31:0]  afterSub;
   logic [127:0] newBlock;
   logic         ready;
`ifdef AES_ENC_BUSY_ERR_EN
   logic         err;
`endif

   logic [7:0]   sbox_t [256];
   logic [127:0] rk [NR+1];
   logic [127:0] sb_q [$];
   logic [3:0]   round_log [$];
   int           n_chk = 0;
   int           n_pass = 0;
   int           err_cnt = 0;
   int           lat;

   always #5 clk = ~clk;

   // Key store and S-box models answer combinationally, like the real neighbours.
   assign roundKey = (round <= 4'(NR)) ? rk[round] : '0;
   assign afterSub = {sbox_t[beforeSub[31:24]], sbox_t[beforeSub[23:16]],
                      sbox_t[beforeSub[15:8]],  sbox_t[beforeSub[7:0]]};

   aes_encipher_block #(.NUM_ROUNDS(NR)) dut (
      .clk(clk), .reset(reset), .next(next), .keyReady(keyReady), .block(block),
      .round(round), .roundKey(roundKey), .beforeSub(beforeSub), .afterSub(afterSub),
      .newBlock(newBlock),
`ifdef AES_ENC_BUSY_ERR_EN
      .err(err),
`endif
      .ready(ready)
   );

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", tag, got, exp);
   endtask

   function automatic logic [7:0] gf_xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = gf_xt(x);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
      logic [15:0] d = {v, v} << n;
      return d[15:8];
   endfunction

   // S-box from first principles: multiplicative inverse followed by the affine map.
   task automatic build_sbox();
      for (int x = 0; x < 256; x++) begin
         logic [7:0] inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   task automatic set_key(input logic [127:0] k);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = k[32*(3-i) +: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rc, 24'h0};
            rc = gf_xt(rc);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r <= NR; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   // Called at a falling edge; returns at the falling edge after the sampling edge (E0).
   task automatic start(input logic [127:0] pt, input logic [127:0] exp, input bit hold);
      block = pt;
      next = 1'b1;
      sb_q.push_back(exp);
      round_log.delete();
      err_cnt = 0;
      @(negedge clk);
      if (!hold) next = 1'b0;
   endtask

   // lat = number of edges after E0 at which ready is first seen high.
   task automatic wait_done(output int l);
      l = 0;
      while (1) begin
         if (round_log.size() == 0 || round_log[round_log.size()-1] != round)
            round_log.push_back(round);
`ifdef AES_ENC_BUSY_ERR_EN
         if (err === 1'b1) err_cnt++;
`endif
         if (ready === 1'b1 || l >= 200) break;
         @(negedge clk);
         l++;
      end
   endtask

   task automatic finish_run(input string tag);
      logic [127:0] exp;
      wait_done(lat);
      next = 1'b0;
      check_eq({tag, "_latency"}, 128'(lat), 128'(51));
      exp = (sb_q.size() > 0) ? sb_q.pop_front() : 'x;
      check_eq({tag, "_ct"}, newBlock, exp);
   endtask

   initial begin
      build_sbox();
      set_key(KEY_B);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check_eq("rst_ready", 128'(ready), 128'(1));
      check_eq("rst_round", 128'(round), 128'(0));
      check_eq("rst_newBlock", newBlock, '0);
      check_eq("rst_beforeSub", 128'(beforeSub), '0);
`ifdef AES_ENC_BUSY_ERR_EN
      check_eq("rst_err", 128'(err), 128'(0));
`endif

      // Requests without stored keys are dropped.
      keyReady = 1'b0;
      next = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_eq("nokey_ready", 128'(ready), 128'(1));
         check_eq("nokey_round", 128'(round), 128'(0));
`ifdef AES_ENC_BUSY_ERR_EN
         check_eq("nokey_err", 128'(err), 128'(1));
`endif
      end
      next = 1'b0;
      @(negedge clk);
      check_eq("nokey_ready_after", 128'(ready), 128'(1));
`ifdef AES_ENC_BUSY_ERR_EN
      check_eq("nokey_err_clear", 128'(err), 128'(0));
`endif
      keyReady = 1'b1;

      // FIPS-197 Appendix B, then check the result holds while idle.
      start(PT_B, CT_B, 1'b0);
      finish_run("appB");
      repeat (3) @(negedge clk);
      check_eq("appB_hold", newBlock, CT_B);

      // FIPS-197 Appendix C.1 with the round index sequence.
      set_key(KEY_C);
      start(PT_C, CT_C, 1'b0);
      finish_run("appC");
      check_eq("appC_round_cnt", 128'(round_log.size()), 128'(NR + 1));
      for (int i = 0; i <= NR && i < round_log.size(); i++)
         check_eq($sformatf("appC_round%0d", i), 128'(round_log[i]), 128'(i));

      // next held high for the whole run: only one encryption starts.
      @(negedge clk);
      set_key(KEY_B);
      start(PT_B, CT_B, 1'b1);
      finish_run("held");
`ifdef AES_ENC_BUSY_ERR_EN
      check_eq("held_err_pulses", 128'(err_cnt), 128'(51));
`endif
      @(negedge clk);
      check_eq("held_no_restart_ready", 128'(ready), 128'(1));
      check_eq("held_no_restart_round", 128'(round), 128'(NR));

      // Reset in the middle of a block discards it.
      start(PT_C, CT_C, 1'b0);
      repeat (19) @(negedge clk);
      @(posedge clk);
      reset = 1'b1;
      #1;
      check_eq("midrst_ready", 128'(ready), 128'(1));
      check_eq("midrst_round", 128'(round), 128'(0));
      check_eq("midrst_newBlock", newBlock, '0);
      if (sb_q.size() > 0) void'(sb_q.pop_front());
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      start(PT_B, CT_B, 1'b0);
      finish_run("postrst");

      // Back-to-back: second start the cycle ready is seen high, with a new key.
      @(negedge clk);
      start(PT_B, CT_B, 1'b0);
      finish_run("b2b_first");
      set_key(KEY_C);
      start(PT_C, CT_C, 1'b0);
      finish_run("b2b_second");
      check_eq("sb_empty", 128'(sb_q.size()), 128'(0));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
